// File: rtl/pipe_alu_core_if.sv
// Issue/retire bus of pipe_alu_core: valid/ready instruction issue toward the core,
// registered result, destination and flags back from the write-back stage.
interface pipe_alu_core_if #(
   parameter int DATA_W    = 16,
   parameter int NREG      = 16,
   parameter int MEM_DEPTH = 256
);
   localparam int REG_AW = $clog2(NREG);
   localparam int MEM_AW = $clog2(MEM_DEPTH);

   logic              in_valid;
   logic              in_ready;
   logic [3:0]        func;
   logic [REG_AW-1:0] rs1;
   logic [REG_AW-1:0] rs2;
   logic [REG_AW-1:0] rd;
   logic [MEM_AW-1:0] addr;
   logic [DATA_W-1:0] zout;
   logic [REG_AW-1:0] out_rd;
   logic              out_valid;
   logic              flag_z;
   logic              flag_c;

   modport master (
      output in_valid, func, rs1, rs2, rd, addr,
      input  in_ready, zout, out_rd, out_valid, flag_z, flag_c
   );

   modport slave (
      input  in_valid, func, rs1, rs2, rd, addr,
      output in_ready, zout, out_rd, out_valid, flag_z, flag_c
   );
endinterface

// File: rtl/pipe_alu_core.sv
// Three-stage register-read / execute-or-memory / write-back pipeline.
// Build option PIPE_FWD_EN: operand forwarding; otherwise hazards stall issue.
module pipe_alu_core #(
   parameter int DATA_W    = 16,
   parameter int NREG      = 16,
   parameter int MEM_DEPTH = 256
) (
   input logic            clk,
   input logic            rst_n,
   pipe_alu_core_if.slave bus
);
   localparam int REG_AW = $clog2(NREG);
   localparam int MEM_AW = $clog2(MEM_DEPTH);

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_SELA  = 4'd3;
   localparam logic [3:0] OP_SELB  = 4'd4;
   localparam logic [3:0] OP_NOTA  = 4'd5;
   localparam logic [3:0] OP_OR    = 4'd6;
   localparam logic [3:0] OP_XOR   = 4'd7;
   localparam logic [3:0] OP_LOAD  = 4'd8;
   localparam logic [3:0] OP_STORE = 4'd9;
   localparam logic [3:0] OP_SHL   = 4'd10;
   localparam logic [3:0] OP_SHR   = 4'd11;

   function automatic logic is_writer(input logic [3:0] f);
      return (f <= OP_LOAD) || (f == OP_SHL) || (f == OP_SHR);
   endfunction

   // Result in [DATA_W-1:0]; bit DATA_W is carry/borrow, zero for non-arithmetic ops.
   function automatic logic [DATA_W:0] alu_op(input logic [3:0]        f,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] m);
      logic [DATA_W:0] r;
      r = '0;
      case (f)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {1'b0, a} - {1'b0, b};
         OP_AND:  r = {1'b0, a & b};
         OP_SELA: r = {1'b0, a};
         OP_SELB: r = {1'b0, b};
         OP_NOTA: r = {1'b0, ~a};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_LOAD: r = {1'b0, m};
         OP_SHL:  r = {1'b0, a << b[3:0]};
         OP_SHR:  r = {1'b0, a >> b[3:0]};
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [DATA_W-1:0] regbank [NREG];
   logic [DATA_W-1:0] mem     [MEM_DEPTH];

   logic              vld_p0;
   logic [3:0]        func_p0;
   logic [REG_AW-1:0] rd_p0;
   logic [MEM_AW-1:0] addr_p0;
   logic [DATA_W-1:0] a_p0;
   logic [DATA_W-1:0] b_p0;

   // vld_p1 marks a valid register writer headed for write-back
   logic              vld_p1;
   logic [REG_AW-1:0] rd_p1;
   logic [DATA_W-1:0] res_p1;
   logic              c_p1;

   logic [DATA_W:0]   alu_s2;
   logic              wr_s2;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic              accept;

   assign alu_s2 = alu_op(func_p0, a_p0, b_p0, mem[addr_p0]);
   assign wr_s2  = vld_p0 && is_writer(func_p0);
   assign accept = bus.in_valid && bus.in_ready;

   // Youngest producer wins: S2 combinational result over the S2 register over regbank.
   always_comb begin
      opa = regbank[bus.rs1];
      opb = regbank[bus.rs2];
      if (vld_p1 && (rd_p1 == bus.rs1)) opa = res_p1;
      if (vld_p1 && (rd_p1 == bus.rs2)) opb = res_p1;
`ifdef PIPE_FWD_EN
      if (wr_s2 && (rd_p0 == bus.rs1)) opa = alu_s2[DATA_W-1:0];
      if (wr_s2 && (rd_p0 == bus.rs2)) opb = alu_s2[DATA_W-1:0];
`endif
   end

`ifdef PIPE_FWD_EN
   assign bus.in_ready = 1'b1;
`else
   logic hit_p0;
   logic hit_p1;
   assign hit_p0 = wr_s2 && ((rd_p0 == bus.rs1) || (rd_p0 == bus.rs2));
   assign hit_p1 = vld_p1 && ((rd_p1 == bus.rs1) || (rd_p1 == bus.rs2));
   assign bus.in_ready = !(bus.in_valid && (hit_p0 || hit_p1));
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p0 <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p0 <= accept;
         vld_p1 <= wr_s2;
      end
   end

   // ---- S1 register: decoded instruction and operands ----
   always_ff @(posedge clk) begin
      func_p0 <= bus.func;
      rd_p0   <= bus.rd;
      addr_p0 <= bus.addr;
      a_p0    <= opa;
      b_p0    <= opb;
   end

   // ---- S2 register: execute / memory result ----
   always_ff @(posedge clk) begin
      rd_p1  <= rd_p0;
      res_p1 <= alu_s2[DATA_W-1:0];
      c_p1   <= alu_s2[DATA_W];
   end

   always_ff @(posedge clk) begin
      if (rst_n && vld_p0 && (func_p0 == OP_STORE)) mem[addr_p0] <= a_p0;
   end

   // ---- S3: write-back and registered outputs ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regbank[i] <= '0;
      end else if (vld_p1) begin
         regbank[rd_p1] <= res_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.zout      <= '0;
         bus.out_rd    <= '0;
         bus.flag_z    <= 1'b0;
         bus.flag_c    <= 1'b0;
      end else begin
         bus.out_valid <= vld_p1;
         if (vld_p1) begin
            bus.zout   <= res_p1;
            bus.out_rd <= rd_p1;
            bus.flag_z <= (res_p1 == '0);
            bus.flag_c <= c_p1;
         end
      end
   end
endmodule

// File: doc/pipe_alu_core.md
Name: pipe_alu_core

Overview:
Parametrised three-stage register/ALU/memory pipeline, the single-clock successor of the team's two-phase four-stage datapath. Stages: register read (S1), execute with ALU or data-memory access (S2), register write-back with result output (S3). Adds over the previous generation: a valid/ready issue handshake, sync reset, operand forwarding, shift ops, carry and zero flags, and an out_valid strobe.

Parameters:
DATA_W, 16, datapath and register width
NREG, 16, number of general registers; REG_AW = $clog2(NREG)
MEM_DEPTH, 256, data-memory words; MEM_AW = $clog2(MEM_DEPTH)

Ports:
clk  in  1  single rising-edge clock
rst_n  in  1  reset, synchronous, active-low
in_valid  in  1  instruction present
in_ready  out  1  pipeline accepts instruction this cycle
func  in  4  opcode
rs1  in  REG_AW  source A register
rs2  in  REG_AW  source B register
rd  in  REG_AW  destination register
addr  in  MEM_AW  memory address for LOAD/STORE
zout  out  DATA_W  S3 result
out_rd  out  REG_AW  destination of the S3 result
out_valid  out  1  zout/out_rd/flags hold a retiring register-writing instruction
flag_z  out  1  zout == 0
flag_c  out  1  carry (ADD) / borrow (SUB); 0 for all other ops

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at rising edge): all stage valids 0; regbank cleared to 0; zout=0, out_rd=0, out_valid=0, flag_z=0, flag_c=0; in_ready=1 after reset. Data memory is not cleared. Reset mid-flight discards every in-flight instruction; no register or memory write happens at that edge.
- Accept: edge E0 with in_valid&in_ready latches func/rd/addr and operands A,B into S1. The instruction executes in S2 between E0 and E1; the S2 register captures the result at E1. At E2 the result is written to regbank[rd] and driven on zout/out_rd with out_valid=1 for one cycle. Throughput is 1 instruction/cycle when not stalled.
- Opcodes (func):
  - 0 ADD; 1 SUB (both wrap mod 2^DATA_W); 2 AND; 3 SELA; 4 SELB; 5 NOT A; 6 OR; 7 XOR.
  - 8 LOAD: mem[addr], asynchronous read in S2.
  - 9 STORE: mem[addr] <= A at E1; no register write; out_valid stays 0.
  - 10 SHL: A << B[3:0]; 11 SHR: A >> B[3:0], logical.
  - 12-15 NOP: no writes; out_valid stays 0.
- Writers are ops 0-8 and 10-11. Only writers raise out_valid and write regbank.
- Operand read priority: (1) S2 combinational result, if the S2 instruction is a valid writer and its rd matches; (2) S2-register result, if the S3-bound instruction is a valid writer and its rd matches; (3) regbank. A register written at an edge is readable by an instruction accepted at that same edge (write-through bypass).
- Memory ordering: a LOAD one cycle behind a STORE to the same addr returns the stored value. A STORE's A operand uses the forwarded value.
- Flags are registered with zout. flag_c is bit DATA_W of the (DATA_W+1)-bit sum/difference.
- Same rd written by back-to-back instructions: the younger value wins in regbank and in forwarding.

Optional Feature:
PIPE_FWD_EN. Defined: forwarding as above; in_ready is constant 1 after reset. Undefined: no forwarding paths, regbank read only, write-through bypass kept. in_ready=0 while in_valid and rs1 or rs2 matches the rd of a valid writer in S1 or S2. The stall lasts until the producer reaches S3; stalled cycles insert bubbles. An instruction presented while in_ready=0 is not accepted and must be held by the source.

Test Plan:
- Reset, then 16 back-to-back SELA r0..r15 -> each zout=0, out_valid one cycle per instruction, in_ready=1 throughout.
- Preload r1=0xFFFF, r2=0x0001; ADD rd=r3 -> zout=0x0000, flag_z=1, flag_c=1 at E2. SUB r2-r1 -> zout=0x0002, flag_c=1.
- Back-to-back dependent chain ADD r3=r1+r2, ADD r4=r3+r3, ADD r5=r4+r3, with r1=2, r2=3 -> zout 5, 10, 15 on consecutive cycles with PIPE_FWD_EN. Without it: same values, in_ready low for 2 cycles before each dependent instruction.
- STORE addr=0x10 with A=r1=0x1234, then next cycle LOAD addr=0x10 rd=r6 -> zout=0x1234; no out_valid for the STORE.
- SHL A=0x0001 B=15 -> 0x8000; SHR A=0x8000 B=4 -> 0x0800; func=13 -> out_valid=0, regbank unchanged.
- rst_n low for one edge with 3 instructions in flight -> out_valid=0 for the next 2 cycles; no regbank or memory change from them; regbank reads 0.
